// File: rtl/dmp_shared_update_sched.sv
// Scheduler between per-thread scatter lanes and the shared update path: owned updates pass
// straight through, shared updates are parked per lane and drained in thread-ID order at the barrier.
module dmp_shared_update_sched #(
  parameter int unsigned NUM_HW_THREADS = 8,
  parameter int unsigned NODE_ID_W      = 32,
  parameter int unsigned VAL_W          = 32,
  parameter int unsigned TID_W          = $clog2(NUM_HW_THREADS)
) (
  input  logic                                clock,
  input  logic                                reset_n,
  input  logic [NUM_HW_THREADS-1:0]           req_valid,
  input  logic [NUM_HW_THREADS-1:0]           req_shared,
  input  logic [NUM_HW_THREADS*NODE_ID_W-1:0] req_dest,
  input  logic [NUM_HW_THREADS*VAL_W-1:0]     req_val,
  output logic [NUM_HW_THREADS-1:0]           req_ready,
  input  logic [NUM_HW_THREADS-1:0]           thread_done,
  output logic [NUM_HW_THREADS-1:0]           local_valid,
  output logic [NUM_HW_THREADS*NODE_ID_W-1:0] local_dest,
  output logic [NUM_HW_THREADS*VAL_W-1:0]     local_val,
  output logic                                sh_valid,
  input  logic                                sh_ready,
  output logic [TID_W-1:0]                    sh_tid,
  output logic [NODE_ID_W-1:0]                sh_dest,
  output logic [VAL_W-1:0]                    sh_val,
  output logic                                stall_scatter,
  input  logic                                next_iteration,
  output logic                                iteration_done
);

  typedef enum logic [1:0] {StCollect, StDrain, StDone} state_e;

  state_e                            state_q, state_d;
  logic [NUM_HW_THREADS-1:0]         slot_full_q, slot_full_d;
  logic [NUM_HW_THREADS-1:0]         done_q, done_d;
  logic [NODE_ID_W-1:0]              slot_dest_q [NUM_HW_THREADS];
  logic [VAL_W-1:0]                  slot_val_q  [NUM_HW_THREADS];
  logic [NUM_HW_THREADS-1:0]         local_valid_q;
  logic [NUM_HW_THREADS*NODE_ID_W-1:0] local_dest_q;
  logic [NUM_HW_THREADS*VAL_W-1:0]   local_val_q;
  logic                              stall_q, iter_done_q;

  logic [NUM_HW_THREADS-1:0]         accept, accept_sh, accept_own;
  logic [NUM_HW_THREADS-1:0]         sel_oh, sh_clr;
  logic [TID_W-1:0]                  sel_tid;
  logic                              found;

  assign req_ready  = {NUM_HW_THREADS{state_q == StCollect}} & ~slot_full_q & ~done_q;
  assign accept     = req_valid & req_ready;
  assign accept_sh  = accept & req_shared;
  assign accept_own = accept & ~req_shared;

  // Lowest-index full slot wins, giving a deterministic drain order.
  always_comb begin
    found   = 1'b0;
    sel_tid = '0;
    sel_oh  = '0;
    for (int i = 0; i < NUM_HW_THREADS; i++) begin
      if (slot_full_q[i] && !found) begin
        found     = 1'b1;
        sel_tid   = TID_W'(i);
        sel_oh[i] = 1'b1;
      end
    end
  end

  assign sh_valid = (state_q == StDrain) && found;
  assign sh_tid   = sh_valid ? sel_tid : '0;
  assign sh_dest  = sh_valid ? slot_dest_q[sel_tid] : '0;
  assign sh_val   = sh_valid ? slot_val_q[sel_tid] : '0;
  assign sh_clr   = (sh_valid && sh_ready) ? sel_oh : '0;

  assign slot_full_d = (slot_full_q | accept_sh) & ~sh_clr;

  // Transitions look at next-state slot/done vectors so the move happens on the settling edge.
  always_comb begin
    state_d = state_q;
    done_d  = done_q | thread_done;
    unique case (state_q)
      StCollect: begin
        if (&(slot_full_d | done_d) && |slot_full_d) begin
          state_d = StDrain;
        end else if (&done_d && !(|slot_full_d)) begin
          state_d = StDone;
        end
      end
      StDrain: begin
        if (!(|slot_full_d)) state_d = StCollect;
      end
      StDone: begin
        if (next_iteration) begin
          state_d = StCollect;
          done_d  = '0;
        end
      end
      default: state_d = StCollect;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StCollect;
      slot_full_q   <= '0;
      done_q        <= '0;
      local_valid_q <= '0;
      local_dest_q  <= '0;
      local_val_q   <= '0;
      stall_q       <= 1'b0;
      iter_done_q   <= 1'b0;
      for (int i = 0; i < NUM_HW_THREADS; i++) begin
        slot_dest_q[i] <= '0;
        slot_val_q[i]  <= '0;
      end
    end else begin
      state_q       <= state_d;
      slot_full_q   <= slot_full_d;
      done_q        <= done_d;
      local_valid_q <= accept_own;
      stall_q       <= (state_d != StCollect);
      iter_done_q   <= (state_d == StDone);
      for (int i = 0; i < NUM_HW_THREADS; i++) begin
        if (accept_sh[i]) begin
          slot_dest_q[i] <= req_dest[i*NODE_ID_W +: NODE_ID_W];
          slot_val_q[i]  <= req_val[i*VAL_W +: VAL_W];
        end
        if (accept_own[i]) begin
          local_dest_q[i*NODE_ID_W +: NODE_ID_W] <= req_dest[i*NODE_ID_W +: NODE_ID_W];
          local_val_q[i*VAL_W +: VAL_W]          <= req_val[i*VAL_W +: VAL_W];
        end
      end
    end
  end

  assign local_valid    = local_valid_q;
  assign local_dest     = local_dest_q;
  assign local_val      = local_val_q;
  assign stall_scatter  = stall_q;
  assign iteration_done = iter_done_q;

endmodule

// File: tb/tb_dmp_shared_update_sched.sv
// Directed bench for dmp_shared_update_sched: owned pass-through, ordered drain, backpressure,
// barrier hold, iteration hand-off and asynchronous reset mid-drain.
module tb_dmp_shared_update_sched;

  logic         clock = 1'b0;
  logic         reset_n;
  logic [7:0]   req_valid, req_shared, req_ready, thread_done, local_valid;
  logic [255:0] req_dest, req_val, local_dest, local_val;
  logic         sh_valid, sh_ready, stall_scatter, next_iteration, iteration_done;
  logic [2:0]   sh_tid;
  logic [31:0]  sh_dest, sh_val;

  int passed = 0;
  int total  = 0;

  dmp_shared_update_sched #(
    .NUM_HW_THREADS(8), .NODE_ID_W(32), .VAL_W(32), .TID_W(3)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_shared(req_shared), .req_dest(req_dest), .req_val(req_val),
    .req_ready(req_ready), .thread_done(thread_done),
    .local_valid(local_valid), .local_dest(local_dest), .local_val(local_val),
    .sh_valid(sh_valid), .sh_ready(sh_ready), .sh_tid(sh_tid), .sh_dest(sh_dest),
    .sh_val(sh_val), .stall_scatter(stall_scatter), .next_iteration(next_iteration),
    .iteration_done(iteration_done)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input int lane, input logic v, input logic s,
                       input logic [31:0] d, input logic [31:0] val);
    req_valid[lane]           = v;
    req_shared[lane]          = s;
    req_dest[lane*32 +: 32]   = d;
    req_val[lane*32 +: 32]    = val;
  endtask

  task automatic do_reset();
    reset_n        = 1'b0;
    req_valid      = '0;
    req_shared     = '0;
    req_dest       = '0;
    req_val        = '0;
    thread_done    = '0;
    sh_ready       = 1'b0;
    next_iteration = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    req_valid = '0; req_shared = '0; req_dest = '0; req_val = '0;
    thread_done = '0; sh_ready = 1'b0; next_iteration = 1'b0;
    #3;
    total++; if (req_ready !== 8'hFF) $display("FAIL reset_ready got %h exp ff", req_ready); else passed++;
    total++; if (sh_valid !== 1'b0) $display("FAIL reset_sh_valid got %b exp 0", sh_valid); else passed++;
    total++; if ({stall_scatter, iteration_done} !== 2'b00)
      $display("FAIL reset_stall_done got %b exp 00", {stall_scatter, iteration_done}); else passed++;
    step();
    total++; if (local_valid !== 8'h00 || local_dest !== '0 || sh_tid !== 3'd0)
      $display("FAIL reset_outputs got lv=%h tid=%0d exp 0", local_valid, sh_tid); else passed++;
    reset_n = 1'b1;
  endtask

  task automatic test_owned();
    do_reset();
    drive(2, 1'b1, 1'b0, 32'd5, 32'h100);
    total++; if (req_ready[2] !== 1'b1) $display("FAIL owned_ready got %b exp 1", req_ready[2]); else passed++;
    step();
    drive(2, 1'b0, 1'b0, 32'd0, 32'd0);
    total++; if (local_valid !== 8'b0000_0100)
      $display("FAIL owned_pulse got %b exp 00000100", local_valid); else passed++;
    total++; if (local_dest[64 +: 32] !== 32'd5 || local_val[64 +: 32] !== 32'h100)
      $display("FAIL owned_data got %h/%h exp 5/100", local_dest[64 +: 32], local_val[64 +: 32]);
    else passed++;
    total++; if (sh_valid !== 1'b0) $display("FAIL owned_sh got %b exp 0", sh_valid); else passed++;
    step();
    total++; if (local_valid !== 8'h00) $display("FAIL owned_once got %b exp 0", local_valid); else passed++;
  endtask

  task automatic test_ordering();
    do_reset();
    thread_done = 8'b1011_0101;
    drive(6, 1'b1, 1'b1, 32'h66, 32'hA6);
    step();
    drive(6, 1'b0, 1'b0, 32'd0, 32'd0);
    step();
    drive(1, 1'b1, 1'b1, 32'h11, 32'hA1);
    step();
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
    total++; if (stall_scatter !== 1'b0 || sh_valid !== 1'b0)
      $display("FAIL order_wait got stall=%b shv=%b exp 0/0", stall_scatter, sh_valid); else passed++;
    step();
    drive(3, 1'b1, 1'b1, 32'h33, 32'hA3);
    step();
    drive(3, 1'b0, 1'b0, 32'd0, 32'd0);
    total++; if (sh_valid !== 1'b1 || sh_tid !== 3'd1 || sh_dest !== 32'h11)
      $display("FAIL order_first got v=%b tid=%0d dest=%h exp 1/1/11", sh_valid, sh_tid, sh_dest);
    else passed++;
    total++; if (stall_scatter !== 1'b1) $display("FAIL order_stall got %b exp 1", stall_scatter); else passed++;
    sh_ready = 1'b1;
    step();
    total++; if (sh_tid !== 3'd3 || sh_val !== 32'hA3)
      $display("FAIL order_second got tid=%0d val=%h exp 3/a3", sh_tid, sh_val); else passed++;
    step();
    total++; if (sh_tid !== 3'd6 || sh_dest !== 32'h66)
      $display("FAIL order_third got tid=%0d dest=%h exp 6/66", sh_tid, sh_dest); else passed++;
    step();
    sh_ready = 1'b0;
    total++; if (sh_valid !== 1'b0 || stall_scatter !== 1'b0 || req_ready !== 8'b0100_1010)
      $display("FAIL order_return got v=%b stall=%b rdy=%b exp 0/0/01001010",
               sh_valid, stall_scatter, req_ready); else passed++;
  endtask

  task automatic test_backpressure();
    do_reset();
    thread_done = 8'b1101_1011;
    drive(2, 1'b1, 1'b1, 32'h22, 32'hA2);
    drive(5, 1'b1, 1'b1, 32'h55, 32'hA5);
    step();
    drive(2, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(5, 1'b0, 1'b0, 32'd0, 32'd0);
    for (int c = 0; c < 4; c++) begin
      total++; if (sh_valid !== 1'b1 || sh_tid !== 3'd2 || sh_dest !== 32'h22 || sh_val !== 32'hA2)
        $display("FAIL bp_hold%0d got v=%b tid=%0d dest=%h val=%h exp 1/2/22/a2",
                 c, sh_valid, sh_tid, sh_dest, sh_val); else passed++;
      step();
    end
    sh_ready = 1'b1;
    step();
    sh_ready = 1'b0;
    total++; if (sh_valid !== 1'b1 || sh_tid !== 3'd5 || sh_val !== 32'hA5)
      $display("FAIL bp_next got v=%b tid=%0d val=%h exp 1/5/a5", sh_valid, sh_tid, sh_val);
    else passed++;
    step();
    total++; if (sh_tid !== 3'd5) $display("FAIL bp_nodup got tid=%0d exp 5", sh_tid); else passed++;
    sh_ready = 1'b1;
    step();
    sh_ready = 1'b0;
    total++; if (sh_valid !== 1'b0) $display("FAIL bp_empty got %b exp 0", sh_valid); else passed++;
  endtask

  task automatic test_barrier();
    do_reset();
    thread_done = 8'b0111_1110;
    drive(0, 1'b1, 1'b1, 32'h10, 32'hB0);
    step();
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    step();
    total++; if (stall_scatter !== 1'b0 || req_ready[0] !== 1'b0 || req_ready[7] !== 1'b1)
      $display("FAIL barrier_hold got stall=%b rdy0=%b rdy7=%b exp 0/0/1",
               stall_scatter, req_ready[0], req_ready[7]); else passed++;
    drive(7, 1'b1, 1'b0, 32'h77, 32'h7);
    step();
    drive(7, 1'b0, 1'b0, 32'd0, 32'd0);
    total++; if (local_valid !== 8'b1000_0000 || local_dest[224 +: 32] !== 32'h77)
      $display("FAIL barrier_owned got lv=%b dest=%h exp 10000000/77", local_valid,
               local_dest[224 +: 32]); else passed++;
    step();
    total++; if (sh_valid !== 1'b0 || stall_scatter !== 1'b0)
      $display("FAIL barrier_still got v=%b stall=%b exp 0/0", sh_valid, stall_scatter); else passed++;
    thread_done[7] = 1'b1;
    step();
    total++; if (sh_valid !== 1'b1 || sh_tid !== 3'd0 || sh_dest !== 32'h10)
      $display("FAIL barrier_drain got v=%b tid=%0d dest=%h exp 1/0/10", sh_valid, sh_tid, sh_dest);
    else passed++;
  endtask

  task automatic test_iteration_end();
    do_reset();
    thread_done = 8'hFF;
    total++; if (iteration_done !== 1'b0) $display("FAIL iter_early got %b exp 0", iteration_done); else passed++;
    step();
    total++; if (iteration_done !== 1'b1 || stall_scatter !== 1'b1 || req_ready !== 8'h00)
      $display("FAIL iter_done got d=%b stall=%b rdy=%h exp 1/1/00", iteration_done, stall_scatter,
               req_ready); else passed++;
    drive(3, 1'b1, 1'b0, 32'h3, 32'h3);
    step();
    drive(3, 1'b0, 1'b0, 32'd0, 32'd0);
    total++; if (local_valid !== 8'h00 || iteration_done !== 1'b1)
      $display("FAIL iter_ignore got lv=%h d=%b exp 00/1", local_valid, iteration_done); else passed++;
    thread_done = 8'h00;
    next_iteration = 1'b1;
    step();
    next_iteration = 1'b0;
    total++; if (iteration_done !== 1'b0 || req_ready !== 8'hFF || stall_scatter !== 1'b0)
      $display("FAIL iter_next got d=%b rdy=%h stall=%b exp 0/ff/0", iteration_done, req_ready,
               stall_scatter); else passed++;
  endtask

  task automatic test_reset_mid_drain();
    do_reset();
    thread_done = 8'b1110_1111;
    drive(4, 1'b1, 1'b1, 32'h44, 32'hA4);
    step();
    drive(4, 1'b0, 1'b0, 32'd0, 32'd0);
    total++; if (sh_valid !== 1'b1 || sh_tid !== 3'd4)
      $display("FAIL rst_pre got v=%b tid=%0d exp 1/4", sh_valid, sh_tid); else passed++;
    reset_n = 1'b0;
    #1;
    total++; if (sh_valid !== 1'b0 || sh_tid !== 3'd0 || sh_dest !== 32'h0)
      $display("FAIL rst_async got v=%b tid=%0d dest=%h exp 0/0/0", sh_valid, sh_tid, sh_dest);
    else passed++;
    thread_done = 8'h00;
    step();
    reset_n = 1'b1;
    step();
    total++; if (req_ready !== 8'hFF || stall_scatter !== 1'b0 || sh_valid !== 1'b0)
      $display("FAIL rst_after got rdy=%h stall=%b v=%b exp ff/0/0", req_ready, stall_scatter,
               sh_valid); else passed++;
  endtask

  initial begin
    test_reset();
    test_owned();
    test_ordering();
    test_backpressure();
    test_barrier();
    test_iteration_end();
    test_reset_mid_drain();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/dmp_shared_update_sched.md
# dmp_shared_update_sched

Deterministic scheduler between the per-thread scatter lanes and the shared PageRank update path. Updates to thread-owned destinations are forwarded at once on per-lane local ports. Updates to shared destinations are held, one per lane, until every lane reaches a barrier. They are then serialized onto a single shared-update port in ascending thread-ID order, so results are identical on every run. The block also tracks per-iteration completion and hands off to the next iteration.

## Interface
- NUM_HW_THREADS, 8, number of scatter lanes (≥2)
- NODE_ID_W, 32, destination node ID width
- VAL_W, 32, update value width (fixed-point, passed through unmodified)
- TID_W, $clog2(NUM_HW_THREADS), thread-ID width

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- req_valid[N]  in  1  lane i presents an update
- req_shared[N]  in  1  1 = destination shared (not owned by lane i)
- req_dest[N]  in  NODE_ID_W  destination node ID
- req_val[N]  in  VAL_W  update value
- req_ready[N]  out  1  lane i update accepted this cycle when req_valid[i] is also high
- thread_done[N]  in  1  lane i has finished scatter for this iteration (level)
- local_valid[N]  out  1  one-cycle pulse carrying an owned update
- local_dest[N]  out  NODE_ID_W  owned update destination
- local_val[N]  out  VAL_W  owned update value
- sh_valid  out  1  shared update available
- sh_ready  in  1  shared consumer accepts
- sh_tid  out  TID_W  originating lane
- sh_dest  out  NODE_ID_W  shared update destination
- sh_val  out  VAL_W  shared update value
- stall_scatter  out  1  high while not in COLLECT
- next_iteration  in  1  start the next iteration (sampled in DONE only)
- iteration_done  out  1  held high in DONE

## Operation
- FSM states: COLLECT, DRAIN, DONE. Reset state is COLLECT.
- Per-lane state:
  - slot_full[i], slot_dest[i], slot_val[i], slot_tid implied by index.
  - done_q[i]: sticky capture of thread_done[i]. Cleared only on reset or on leaving DONE.
- **req_ready[i]** = (state==COLLECT) & ~slot_full[i] & ~done_q[i]. It is combinational and does not depend on req_valid.
- **Accept with req_shared=0:** registers local_valid/dest/val[i] for exactly one cycle.
- **Accept with req_shared=1:** loads slot[i] and sets slot_full[i].
- settled[i] = slot_full[i] | done_q[i].
- **COLLECT → DRAIN:** all settled[i] and at least one slot_full.
- **COLLECT → DONE:** all done_q[i] and no slot_full.
- **DRAIN:**
  - sh_valid = any slot_full. sh_* select the lowest-index full slot (priority encoder).
  - A handshake (sh_valid & sh_ready) clears that slot.
  - The next lowest full slot is presented the following cycle.
  - After the last slot clears, the FSM goes to COLLECT.
- **DONE:**
  - iteration_done=1, all req_ready=0.
  - next_iteration=1 clears done_q and goes to COLLECT. next_iteration is ignored in every other state.
- Lanes that are not done but have no shared update keep streaming owned updates in COLLECT without blocking.
- **Simultaneous events:**
  - req_valid & req_ready in the same cycle thread_done rises: the request is accepted and done_q sets.
  - Owned and shared updates from different lanes in the same cycle: all are accepted in parallel.
- **Widths:** values and IDs are passed bit-exact. No arithmetic on them.
- **Reset (asynchronous, any state including mid-DRAIN):**
  - Clears slots, done_q and all outputs.
  - A pending shared transfer is dropped, with no handshake completed.

## Timing
- **Reset values:**
  - req_ready[i]=1, since COLLECT is the reset state, no slot is full and done_q=0; it follows the req_ready formula during reset.
  - local_valid=0, local_dest=0, local_val=0.
  - sh_valid=0, sh_tid=0, sh_dest=0, sh_val=0.
  - stall_scatter=0, iteration_done=0.
- **Owned updates:** local_* appear 1 cycle after acceptance.
- **Shared stream:**
  - sh_* are driven from registers through the mux and remain stable while sh_valid & ~sh_ready.
  - Throughput is 1 per cycle with sh_ready held high.
- **State transitions:** the transition is taken at the clock edge on which the condition is true.
  - First sh_valid comes 1 cycle after the last lane settles.
  - COLLECT is re-entered the cycle after the final shared handshake.
- **stall_scatter** is registered with the state (high in DRAIN and DONE).

## Test plan
- **Owned only:** lane 2 sends dest=5, val=0x100, shared=0 → local_valid[2] pulses once, the next cycle, with dest=5 and val=0x100. sh_valid stays 0.
- **Ordering:** lanes 6, 1, 3 send shared updates in cycles 0, 2, 4; all other lanes are done → DRAIN, then sh_tid sequence 1, 3, 6 on three back-to-back cycles with sh_ready=1. Return to COLLECT.
- **Backpressure:** sh_ready=0 for 4 cycles in DRAIN → sh_tid, sh_dest and sh_val remain unchanged. Releasing sh_ready yields exactly one transfer per ready cycle. No duplicates.
- **Barrier hold:** lane 0 has a slot full; lane 7 is neither done nor shared → stays in COLLECT, lane 0 req_ready=0. Lane 7 owned updates keep flowing. Lane 7 raises thread_done → DRAIN.
- **Iteration end:** all thread_done with no slots → iteration_done=1 next cycle. Requests are ignored. next_iteration pulse → COLLECT, all req_ready=1.
- **Reset mid-DRAIN:** assert reset_n=0 while slot 4 is presented → sh_valid=0 immediately. After release, state is COLLECT with all slots empty.
